// File: rtl/wb_ram.sv
// Wishbone classic slave RAM with lane-selective writes, a registered read port,
// optional wait states, a write-protected boot region and error termination.
module wb_ram #(
  parameter int unsigned DAT_WIDTH   = 64,
  parameter int unsigned ADR_WIDTH   = 16,
  parameter int unsigned WORDS       = 128,
  parameter int unsigned GRANULE     = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RO_WORDS    = 8,
  parameter string       INIT_FILE   = ""
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         ram_cyc_i,
  input  logic                         ram_stb_i,
  input  logic                         ram_we_i,
  input  logic [ADR_WIDTH-1:0]         ram_adr_i,
  input  logic [DAT_WIDTH/GRANULE-1:0] ram_sel_i,
  input  logic [DAT_WIDTH-1:0]         ram_dat_i,
  output logic [DAT_WIDTH-1:0]         ram_dat_o,
  output logic                         ram_ack_o,
  output logic                         ram_err_o
);

  localparam int unsigned LANES    = DAT_WIDTH / GRANULE;
  localparam int unsigned OFF_BITS = $clog2(DAT_WIDTH / 8);
  localparam int unsigned IDX_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  state_t                        state, state_nxt;
  logic [3:0]                    cnt, cnt_nxt;
  logic                          r_ack, r_err, ack_nxt, err_nxt;
  logic                          latch, wr_en, rd_en;
  logic [1:0]                    rst_sync;
  logic                          rst_rdy;

  logic [ADR_WIDTH-1:0]          adr_q;
  logic                          we_q;
  logic [LANES-1:0]              sel_q;
  logic [DAT_WIDTH-1:0]          dat_q;

  logic [ADR_WIDTH-OFF_BITS-1:0] index;
  logic [IDX_BITS-1:0]           mem_idx;
  logic                          bad_off, bad_idx, bad_ro, req_err;

  logic [DAT_WIDTH-1:0]          mem [WORDS];

  // Memory starts all-zero and is never reset.
  initial begin
    for (int unsigned w = 0; w < WORDS; w++) mem[IDX_BITS'(w)] = '0;
  end

  assign index   = adr_q[ADR_WIDTH-1:OFF_BITS];
  assign mem_idx = index[IDX_BITS-1:0];
  assign bad_off = |adr_q[OFF_BITS-1:0];
  assign bad_idx = (32'(index) >= WORDS);
  assign bad_ro  = we_q && (32'(index) < RO_WORDS);
  assign req_err = bad_off | bad_idx | bad_ro;

  // Reset asserts immediately but the FSM only accepts requests two edges after release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_rdy = rst_sync[1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = r_ack;
    err_nxt   = r_err;
    latch     = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rst_rdy && ram_cyc_i && ram_stb_i) begin
          latch = 1'b1;
          if (WAIT_STATES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_STATES - 1);
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (!ram_cyc_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        ack_nxt   = !req_err;
        err_nxt   = req_err;
        wr_en     = we_q && !req_err;
        rd_en     = !we_q && !req_err;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (!(ram_cyc_i && ram_stb_i)) begin
          ack_nxt   = 1'b0;
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      r_ack <= ack_nxt;
      r_err <= err_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      adr_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
    end else if (latch) begin
      adr_q <= ram_adr_i;
      we_q  <= ram_we_i;
      sel_q <= ram_sel_i;
      dat_q <= ram_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (sel_q[l]) mem[mem_idx][l*GRANULE +: GRANULE] <= dat_q[l*GRANULE +: GRANULE];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   ram_dat_o <= '0;
    else if (rd_en) ram_dat_o <= mem[mem_idx];
  end

  assign ram_ack_o = r_ack & ram_stb_i & ram_cyc_i;
  assign ram_err_o = r_err & ram_stb_i & ram_cyc_i;

endmodule

// File: tb/tb_wb_ram.sv
// Self-checking bench for wb_ram (64-bit, 128 words, 8 protected, 2 wait states):
// directed cases followed by randomized accesses against a word-array model.
module tb_wb_ram;

    localparam int unsigned NW = 128;
    localparam int unsigned RO = 8;
    localparam int unsigned WS = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [15:0] adr   = '0;
    logic [7:0]  sel   = '0;
    logic [63:0] wdat  = '0;
    logic [63:0] rdat;
    logic        ack, err;

    always #5 clk = ~clk;

    wb_ram #(
        .DAT_WIDTH(64), .ADR_WIDTH(16), .WORDS(128), .GRANULE(8),
        .WAIT_STATES(2), .RO_WORDS(8), .INIT_FILE("")
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .ram_cyc_i(cyc), .ram_stb_i(stb), .ram_we_i(we),
        .ram_adr_i(adr), .ram_sel_i(sel), .ram_dat_i(wdat),
        .ram_dat_o(rdat), .ram_ack_o(ack), .ram_err_o(err)
    );

    logic [63:0] ref_mem [NW];
    logic [63:0] ref_dat = '0;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic bit ref_err(input logic w, input logic [15:0] a);
        int unsigned idx;
        idx = 32'(a >> 3);
        return (a[2:0] != 3'd0) || (idx >= NW) || (w && idx < RO);
    endfunction

    // One complete access: drive, wait for termination, optionally keep the strobe
    // held, then release and confirm the termination disappears at once.
    task automatic xfer(input logic w, input logic [15:0] a, input logic [7:0] s,
                        input logic [63:0] d, input int hold, input string tag);
        bit          e_exp;
        bit          seen;
        int          lat;
        logic [6:0]  i7;
        logic [63:0] mask;
        e_exp = ref_err(w, a);
        i7    = a[9:3];
        seen  = 1'b0;
        lat   = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ack || err) seen = 1'b1;
        end
        check({tag, "/seen"}, 64'(seen), 64'(1));
        check({tag, "/latency"}, 64'(lat - 1), 64'(WS + 1));
        check({tag, "/ack"}, 64'(ack), 64'(!e_exp));
        check({tag, "/err"}, 64'(err), 64'(e_exp));
        if (!e_exp && w) begin
            mask = '0;
            for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{s[b]}};
            ref_mem[i7] = (ref_mem[i7] & ~mask) | (d & mask);
        end
        if (!e_exp && !w) ref_dat = ref_mem[i7];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "/held"}, 64'({ack, err}), 64'({!e_exp, e_exp}));
        end
        check({tag, "/rdat"}, rdat, ref_dat);
        cyc = 1'b0; stb = 1'b0;
        #1;
        check({tag, "/release"}, 64'({ack, err}), 64'(0));
    endtask

    initial begin
        logic [15:0] ra;
        logic        rw;
        int          spurious;

        for (int k = 0; k < NW; k++) ref_mem[k] = '0;

        // Reset state, with a strobe presented while reset is held.
        cyc = 1'b1; stb = 1'b1;
        repeat (3) @(negedge clk);
        check("reset/rdat", rdat, 64'(0));
        check("reset/ackerr", 64'({ack, err}), 64'(0));
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Full write then read back.
        xfer(1'b1, 16'h0040, 8'hFF, 64'h1122334455667788, 0, "w40");
        xfer(1'b0, 16'h0040, 8'hFF, '0, 0, "r40");
        check("r40/const", rdat, 64'h1122334455667788);

        // Partial lane write.
        xfer(1'b1, 16'h0040, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 0, "w40p");
        xfer(1'b0, 16'h0040, 8'h00, '0, 0, "r40p");
        check("r40p/const", rdat, 64'h11223344AAAAAAAA);

        // Error terminations.
        xfer(1'b1, 16'h0010, 8'hFF, 64'hDEADBEEFCAFEF00D, 0, "wprot");
        xfer(1'b0, 16'h0010, 8'hFF, '0, 0, "rprot");
        xfer(1'b0, 16'h0040, 8'hFF, '0, 0, "r40again");
        xfer(1'b0, 16'h0400, 8'hFF, '0, 0, "roob");
        xfer(1'b0, 16'h0043, 8'hFF, '0, 0, "rmis");
        check("rmis/keep", rdat, 64'h11223344AAAAAAAA);
        xfer(1'b1, 16'h0045, 8'hFF, 64'h5555555555555555, 0, "wmis");

        // Empty select still acknowledges and leaves the word alone.
        xfer(1'b1, 16'h0048, 8'h00, 64'hFFFFFFFFFFFFFFFF, 0, "wsel0");
        xfer(1'b0, 16'h0048, 8'hFF, '0, 0, "rsel0");

        // Held strobe: one termination, ack continuously high, no second access.
        xfer(1'b1, 16'h0050, 8'hFF, 64'h0123456789ABCDEF, 0, "wh");
        xfer(1'b0, 16'h0050, 8'hFF, '0, 10, "hold");

        // Cycle abandoned during the wait phase.
        xfer(1'b1, 16'h0080, 8'hFF, 64'hA5A5A5A55A5A5A5A, 0, "wabt0");
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0080; sel = 8'hFF; wdat = 64'hFFFF0000FFFF0000;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        spurious = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack || err) spurious++;
        end
        check("abort/term", 64'(spurious), 64'(0));
        xfer(1'b0, 16'h0080, 8'hFF, '0, 0, "rabt");

        // Reset asserted the cycle before a write response.
        xfer(1'b1, 16'h0088, 8'hFF, 64'h0F0F0F0F0F0F0F0F, 0, "wrst0");
        xfer(1'b0, 16'h0040, 8'hFF, '0, 0, "rpre");
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0088; sel = 8'hFF; wdat = 64'hF0F0F0F0F0F0F0F0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst/rdat_async", rdat, 64'(0));
        check("rst/ackerr", 64'({ack, err}), 64'(0));
        ref_dat = '0;
        repeat (2) @(negedge clk);
        check("rst/ackerr_held", 64'({ack, err}), 64'(0));
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        xfer(1'b0, 16'h0088, 8'hFF, '0, 0, "rpost");
        xfer(1'b1, 16'h0088, 8'h3C, {$urandom, $urandom}, 0, "wpost");
        xfer(1'b0, 16'h0088, 8'hFF, '0, 0, "rpost2");

        // Randomized traffic against the model.
        for (int k = 0; k < 40; k++) begin
            ra = 16'($urandom_range(0, 135)) << 3;
            if ($urandom_range(0, 7) == 0) ra = ra | 16'($urandom_range(1, 7));
            rw = 1'($urandom_range(0, 1));
            xfer(rw, ra, 8'($urandom), {$urandom, $urandom},
                 ($urandom_range(0, 3) == 0) ? 2 : 0, "rnd");
        end

        // Read back a spread of words so random writes are confirmed.
        for (int k = 8; k < 40; k += 3) begin
            ra = 16'(k) << 3;
            xfer(1'b0, ra, 8'hFF, '0, 0, "sweep");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1);
    end

endmodule
